// File: rtl/alu_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_arbiter                                                  |
// | Description : Round-robin share of one ALU between two requesters, with   |
// |               a single response channel. Optional ISSUE timeout via macro  |
// |               ALU_ARB_TIMEOUT_EN.                                          |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module alu_arbiter #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_err,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_opcode,
    output logic             alu_enable,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_ack
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ISSUE = 2'd1;
    localparam logic [1:0] c_ST_RESP  = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic             r_last_grant;
    logic             w_grant;
    logic             w_accept;
    logic             w_done;
    logic             w_timeout;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_op;
    logic             r_id;
    logic             r_rsp_id;
    logic [WIDTH-1:0] r_rsp_result;

    // Contention goes to the requester that did not win last time.
    assign w_grant    = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;
    assign req0_ready = (r_state == c_ST_IDLE) && req0_valid && !w_grant;
    assign req1_ready = (r_state == c_ST_IDLE) && req1_valid && w_grant;
    assign w_accept   = req0_ready || req1_ready;
    assign w_done     = (r_state == c_ST_ISSUE) && (alu_ack || w_timeout);

    assign rsp_valid  = (r_state == c_ST_RESP);
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_rsp_result;

`ifdef ALU_ARB_TIMEOUT_EN
    localparam int c_CNT_W = $clog2(TIMEOUT + 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_rsp_err;

    // An ack on the final allowed cycle takes priority over the timeout.
    assign w_timeout = (r_state == c_ST_ISSUE) && !alu_ack &&
                       (r_cnt == c_CNT_W'(TIMEOUT - 1));
    assign rsp_err   = r_rsp_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_rsp_err <= 1'b0;
        end else begin
            if (r_state != c_ST_ISSUE) begin
                r_cnt <= '0;
            end else if (!alu_ack) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_done) begin
                r_rsp_err <= !alu_ack;
            end
        end
    end
`else
    logic w_unused_timeout;

    assign w_timeout        = 1'b0;
    assign rsp_err          = 1'b0;
    assign w_unused_timeout = (TIMEOUT != 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        alu_enable   = 1'b0;
        alu_a        = '0;
        alu_b        = '0;
        alu_opcode   = 3'b000;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = c_ST_ISSUE;
                end
            end
            c_ST_ISSUE: begin
                alu_enable = 1'b1;
                alu_a      = r_a;
                alu_b      = r_b;
                alu_opcode = r_op;
                if (w_done) begin
                    w_next_state = c_ST_RESP;
                end
            end
            c_ST_RESP: begin
                if (rsp_ready) begin
                    w_next_state = c_ST_IDLE;
                end
            end
            default: w_next_state = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= 1'b1;
            r_a          <= '0;
            r_b          <= '0;
            r_op         <= 3'b000;
            r_id         <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= '0;
        end else begin
            if (w_accept) begin
                r_a          <= w_grant ? req1_a  : req0_a;
                r_b          <= w_grant ? req1_b  : req0_b;
                r_op         <= w_grant ? req1_op : req0_op;
                r_id         <= w_grant;
                r_last_grant <= w_grant;
            end
            // The ALU bus floats without ack, so a timeout returns zero instead.
            if (w_done) begin
                r_rsp_id     <= r_id;
                r_rsp_result <= alu_ack ? alu_result : '0;
            end
        end
    end

endmodule
`default_nettype wire
